el2_iccm_acc_ctl: RTL and testbench

EL2_ICCM_ACC_CTL -- requirements
Module: el2_iccm_acc_ctl

---
 rtl/el2_iccm_acc_ctl.sv | 110 +++++++++++
 tb/tb_el2_iccm_acc_ctl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/el2_iccm_acc_ctl.sv
// el2_iccm_acc_ctl: ICCM port arbiter between IFU fetches and DMA, with
// single-bit ECC correction write-back of fetched/DMA read data.
module el2_iccm_acc_ctl #(
    parameter int ICCM_BITS     = 16,
    parameter int DMA_BURST_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ifu_rd_req,
    input  logic [ICCM_BITS-1:1] ifu_rd_addr,
    output logic                 ifu_gnt,
    input  logic                 dma_req,
    input  logic                 dma_write,
    input  logic [ICCM_BITS-1:1] dma_addr,
    input  logic [2:0]           dma_size,
    input  logic [77:0]          dma_wdata,
    output logic                 dma_gnt,
    input  logic                 ecc_sb_err,
    input  logic [77:0]          ecc_corr_data,
    input  logic                 core_ecc_disable,
    output logic [ICCM_BITS-1:1] iccm_rw_addr,
    output logic                 iccm_rden,
    output logic                 iccm_wren,
    output logic [2:0]           iccm_wr_size,
    output logic [77:0]          iccm_wr_data,
    output logic                 iccm_buf_correct_ecc,
    output logic                 iccm_correction_state,
    output logic                 rd_vld,
    output logic                 rd_owner
);
    typedef enum logic [1:0] {IDLE, CORR_HOLD, CORR_WR} state_t;

    state_t               state, next_state;
    logic [1:0]           dma_streak;
    logic [ICCM_BITS-1:1] rd_addr, corr_addr, addr_hold;
    logic [77:0]          corr_data, wdata_hold;
    logic                 ifu_pick, corr_start;

    // IFU wins only when DMA is idle or has used up its burst allowance
    assign ifu_pick = ifu_rd_req && (!dma_req || dma_streak == 2'(DMA_BURST_MAX));

    always_comb begin
        next_state            = state;
        ifu_gnt               = 1'b0;
        dma_gnt               = 1'b0;
        iccm_rden             = 1'b0;
        iccm_wren             = 1'b0;
        iccm_wr_size          = 3'd0;
        iccm_rw_addr          = addr_hold;
        iccm_wr_data          = wdata_hold;
        iccm_buf_correct_ecc  = 1'b0;
        iccm_correction_state = 1'b0;
        corr_start            = 1'b0;
        case (state)
            IDLE: begin
                ifu_gnt      = !rst && ifu_pick;
                dma_gnt      = !rst && dma_req && !ifu_pick;
                iccm_rden    = ifu_gnt || (dma_gnt && !dma_write);
                iccm_wren    = dma_gnt && dma_write;
                iccm_wr_size = iccm_wren ? dma_size : 3'd0;
                iccm_rw_addr = ifu_gnt ? ifu_rd_addr : dma_gnt ? dma_addr : addr_hold;
                iccm_wr_data = iccm_wren ? dma_wdata : wdata_hold;
                corr_start   = rd_vld && ecc_sb_err && !core_ecc_disable;
                next_state   = corr_start ? CORR_HOLD : IDLE;
            end
            CORR_HOLD: begin
                iccm_correction_state = 1'b1;
                next_state            = CORR_WR;
            end
            CORR_WR: begin
                iccm_wren             = 1'b1;
                iccm_wr_size          = 3'b011;
                iccm_rw_addr          = corr_addr;
                iccm_wr_data          = corr_data;
                iccm_buf_correct_ecc  = 1'b1;
                iccm_correction_state = 1'b1;
                next_state            = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dma_streak <= 2'd0;
            rd_vld     <= 1'b0;
            rd_owner   <= 1'b0;
            rd_addr    <= '0;
            corr_addr  <= '0;
            corr_data  <= '0;
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            state      <= next_state;
            dma_streak <= (!ifu_rd_req || ifu_gnt) ? 2'd0 : dma_gnt ? dma_streak + 2'd1 : dma_streak;
            rd_vld     <= iccm_rden;
            addr_hold  <= iccm_rw_addr;
            wdata_hold <= iccm_wr_data;
            if (iccm_rden) begin
                rd_owner <= dma_gnt;
                rd_addr  <= iccm_rw_addr;
            end
            if (corr_start) begin
                corr_addr <= rd_addr;
                corr_data <= ecc_corr_data;
            end
        end
    end
endmodule

// File: tb/tb_el2_iccm_acc_ctl.sv
// tb_el2_iccm_acc_ctl: directed checks of arbitration, read return, ECC
// correction sequence, DMA writes and asynchronous reset behaviour.
module tb_el2_iccm_acc_ctl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ifu_rd_req = 1'b0, dma_req = 1'b0, dma_write = 1'b0;
    logic [15:1] ifu_rd_addr = '0, dma_addr = '0;
    logic [2:0]  dma_size = '0;
    logic [77:0] dma_wdata = '0, ecc_corr_data = '0;
    logic        ecc_sb_err = 1'b0, core_ecc_disable = 1'b0;
    logic        ifu_gnt, dma_gnt, iccm_rden, iccm_wren, iccm_buf_correct_ecc;
    logic        iccm_correction_state, rd_vld, rd_owner;
    logic [15:1] iccm_rw_addr;
    logic [2:0]  iccm_wr_size;
    logic [77:0] iccm_wr_data;
    int          n_cmp = 0, n_err = 0;
    logic [4:0]  pat;
    logic [77:0] cdata;

    el2_iccm_acc_ctl dut (
        .clk(clk), .rst(rst),
        .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_gnt(ifu_gnt),
        .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr),
        .dma_size(dma_size), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .ecc_sb_err(ecc_sb_err), .ecc_corr_data(ecc_corr_data),
        .core_ecc_disable(core_ecc_disable),
        .iccm_rw_addr(iccm_rw_addr), .iccm_rden(iccm_rden), .iccm_wren(iccm_wren),
        .iccm_wr_size(iccm_wr_size), .iccm_wr_data(iccm_wr_data),
        .iccm_buf_correct_ecc(iccm_buf_correct_ecc),
        .iccm_correction_state(iccm_correction_state),
        .rd_vld(rd_vld), .rd_owner(rd_owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_rden", iccm_rden, 0);
        chk("rst_wren", iccm_wren, 0);
        chk("rst_corr_state", iccm_correction_state, 0);
        chk("rst_addr", iccm_rw_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // IFU-only read
        ifu_rd_req = 1'b1; ifu_rd_addr = 15'h10;
        #1;
        chk("ifu_gnt", ifu_gnt, 1);
        chk("ifu_dma_gnt", dma_gnt, 0);
        chk("ifu_rden", iccm_rden, 1);
        chk("ifu_addr", iccm_rw_addr, 15'h10);
        @(negedge clk);
        ifu_rd_req = 1'b0;
        #1;
        chk("ifu_rd_vld", rd_vld, 1);
        chk("ifu_rd_owner", rd_owner, 0);
        chk("idle_rden", iccm_rden, 0);
        chk("idle_addr_hold", iccm_rw_addr, 15'h10);
        @(negedge clk);

        // contention: D D D I D
        dma_req = 1'b1; dma_write = 1'b0; dma_addr = 15'h40;
        ifu_rd_req = 1'b1; ifu_rd_addr = 15'h11;
        pat = 5'b10111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("cont_dma_gnt%0d", i), dma_gnt, pat[i]);
            chk($sformatf("cont_ifu_gnt%0d", i), ifu_gnt, !pat[i]);
            chk($sformatf("cont_addr%0d", i), iccm_rw_addr, pat[i] ? 15'h40 : 15'h11);
            @(negedge clk);
            #1;
            chk($sformatf("cont_rd_vld%0d", i), rd_vld, 1);
            chk($sformatf("cont_owner%0d", i), rd_owner, pat[i]);
        end
        dma_req = 1'b0; ifu_rd_req = 1'b0;
        @(negedge clk);

        // correction: IFU read 0x20 returns a single-bit error
        cdata = 78'h3_FFFF_FFFF_FFFF_FFFF;
        ifu_rd_req = 1'b1; ifu_rd_addr = 15'h20;
        @(negedge clk);
        ifu_rd_req = 1'b0;
        ecc_sb_err = 1'b1; ecc_corr_data = cdata;
        dma_req = 1'b1; dma_addr = 15'h50;
        #1;
        chk("err_rd_vld", rd_vld, 1);
        chk("err_cycle_dma_gnt", dma_gnt, 1);
        @(negedge clk);
        ecc_corr_data = 78'h5;
        ifu_rd_req = 1'b1;
        #1;
        chk("hold_corr_state", iccm_correction_state, 1);
        chk("hold_dma_gnt", dma_gnt, 0);
        chk("hold_ifu_gnt", ifu_gnt, 0);
        chk("hold_wren", iccm_wren, 0);
        chk("hold_buf_corr", iccm_buf_correct_ecc, 0);
        chk("hold_rd_vld", rd_vld, 1);
        chk("hold_rd_owner", rd_owner, 1);
        @(negedge clk);
        ecc_sb_err = 1'b0;
        #1;
        chk("cwr_wren", iccm_wren, 1);
        chk("cwr_size", iccm_wr_size, 3'b011);
        chk("cwr_addr", iccm_rw_addr, 15'h20);
        chk("cwr_data", iccm_wr_data, cdata);
        chk("cwr_buf_corr", iccm_buf_correct_ecc, 1);
        chk("cwr_corr_state", iccm_correction_state, 1);
        chk("cwr_dma_gnt", dma_gnt, 0);
        chk("cwr_ifu_gnt", ifu_gnt, 0);
        chk("cwr_rden", iccm_rden, 0);
        chk("cwr_rd_vld", rd_vld, 0);
        @(negedge clk);
        #1;
        chk("post_corr_state", iccm_correction_state, 0);
        chk("post_dma_gnt", dma_gnt, 1);
        chk("post_wren", iccm_wren, 0);
        dma_req = 1'b0; ifu_rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // ECC disabled: no correction
        ifu_rd_req = 1'b1; ifu_rd_addr = 15'h22;
        @(negedge clk);
        ifu_rd_req = 1'b0; ecc_sb_err = 1'b1; core_ecc_disable = 1'b1; ecc_corr_data = cdata;
        #1;
        chk("dis_rd_vld", rd_vld, 1);
        @(negedge clk);
        ecc_sb_err = 1'b0;
        #1;
        chk("dis_corr_state", iccm_correction_state, 0);
        chk("dis_wren0", iccm_wren, 0);
        @(negedge clk);
        #1;
        chk("dis_wren1", iccm_wren, 0);
        chk("dis_buf_corr", iccm_buf_correct_ecc, 0);
        core_ecc_disable = 1'b0;
        @(negedge clk);

        // DMA write
        dma_req = 1'b1; dma_write = 1'b1; dma_size = 3'b010; dma_addr = 15'h30; dma_wdata = 78'h1234;
        #1;
        chk("dwr_gnt", dma_gnt, 1);
        chk("dwr_wren", iccm_wren, 1);
        chk("dwr_rden", iccm_rden, 0);
        chk("dwr_size", iccm_wr_size, 3'b010);
        chk("dwr_data", iccm_wr_data, 78'h1234);
        chk("dwr_addr", iccm_rw_addr, 15'h30);
        @(negedge clk);
        dma_req = 1'b0; dma_write = 1'b0;
        #1;
        chk("dwr_no_rd_vld", rd_vld, 0);
        chk("dwr_data_hold", iccm_wr_data, 78'h1234);
        chk("dwr_wren_off", iccm_wren, 0);
        @(negedge clk);

        // reset pulsed during CORR_WR
        ifu_rd_req = 1'b1; ifu_rd_addr = 15'h24;
        @(negedge clk);
        ifu_rd_req = 1'b0; ecc_sb_err = 1'b1; ecc_corr_data = 78'h155;
        @(negedge clk);
        ecc_sb_err = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_rst_wren", iccm_wren, 1);
        ifu_rd_req = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_wren", iccm_wren, 0);
        chk("arst_buf_corr", iccm_buf_correct_ecc, 0);
        chk("arst_corr_state", iccm_correction_state, 0);
        chk("arst_ifu_gnt", ifu_gnt, 0);
        chk("arst_rden", iccm_rden, 0);
        chk("arst_addr", iccm_rw_addr, 0);
        @(negedge clk);
        rst = 1'b0; ifu_rd_req = 1'b0;
        #1;
        chk("rel_wren", iccm_wren, 0);
        chk("rel_corr_state", iccm_correction_state, 0);
        @(negedge clk);
        #1;
        chk("rel_wren1", iccm_wren, 0);
        chk("rel_buf_corr", iccm_buf_correct_ecc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
